// File: rtl/boot_loader_if.sv
// boot_loader_if: bus between the serial program loader and its neighbours.
//   start/rx_valid/rx_data  : session request and receiver byte strobe
//   mem_we/mem_im/mem_addr/mem_wd : unified memory write port
//   cpu_hold/busy/done/err/words_written : processor hold and session status
// slave  = the loader itself; master = the side driving bytes and watching writes.
interface boot_loader_if;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        mem_we;
  logic        mem_im;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        err;
  logic [8:0]  words_written;

  modport slave (
    input  start, rx_valid, rx_data,
    output mem_we, mem_im, mem_addr, mem_wd,
    output cpu_hold, busy, done, err, words_written
  );

  modport master (
    output start, rx_valid, rx_data,
    input  mem_we, mem_im, mem_addr, mem_wd,
    input  cpu_hold, busy, done, err, words_written
  );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: receives a length-prefixed, XOR-checksummed byte stream and
// writes it as little-endian 32-bit words into instruction/data memory,
// holding the CPU in reset during the load.
//   clk   : system clock
//   reset : asynchronous active-high reset
//   bus   : boot_loader_if.slave (byte input, memory write port, status)
// Stream format: len[7:0], len[15:8], 4*len data bytes, checksum byte.
module boot_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_WORDS = 256
) (
  input  logic          clk,
  input  logic          reset,
  boot_loader_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_e;

  localparam logic [16:0] MAXW = MAX_WORDS[16:0];

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [23:0] acc_q, acc_d;     // low three bytes of the word in progress
  logic [8:0]  idx_q, idx_d;     // words committed this session
  logic [7:0]  csum_q, csum_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;

  logic [15:0] len_new;
  logic [8:0]  idx_inc;
  assign len_new = {bus.rx_data, len_q[7:0]};
  assign idx_inc = idx_q + 9'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      bcnt_q  <= bcnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    bcnt_d  = bcnt_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    we_d    = 1'b0;   // write strobe is a single-cycle pulse
    addr_d  = addr_q; // address/data hold until the next write
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (bus.start) begin
          state_d = S_LEN0;
          idx_d   = '0;
          bcnt_d  = '0;
          csum_d  = '0;
        end
      end
      S_LEN0: begin
        if (bus.rx_valid) begin
          len_d[7:0] = bus.rx_data;
          csum_d     = csum_q ^ bus.rx_data;
          state_d    = S_LEN1;
        end
      end
      S_LEN1: begin
        if (bus.rx_valid) begin
          len_d[15:8] = bus.rx_data;
          csum_d      = csum_q ^ bus.rx_data;
          if (len_new == 16'd0 || {1'b0, len_new} > MAXW) state_d = S_ERR;
          else                                             state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.rx_valid) begin
          csum_d = csum_q ^ bus.rx_data;
          bcnt_d = bcnt_q + 2'd1;  // wraps to 0 after the 4th byte
          if (bcnt_q == 2'd3) begin
            we_d   = 1'b1;
            wd_d   = {bus.rx_data, acc_q};
            addr_d = BASE_ADDR + {21'd0, idx_q, 2'b00};
            idx_d  = idx_inc;
            if ({7'd0, idx_inc} == len_q) state_d = S_CSUM;
          end else begin
            acc_d[8*bcnt_q +: 8] = bus.rx_data;
          end
        end
      end
      S_CSUM: begin
        if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic active;
  assign active            = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
  assign bus.busy          = active;
  assign bus.cpu_hold      = active;
  assign bus.done          = (state_q == S_DONE);
  assign bus.err           = (state_q == S_ERR);
  assign bus.mem_we        = we_q;
  assign bus.mem_im        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wd        = wd_q;
  assign bus.words_written = idx_q;

endmodule
